// File: rtl/sharp_pkg.sv
// Shared definitions for the Sharp memory-LCD frame sequencer: command
// encodings, FSM state encoding, line-address width and the range check.
package sharp_pkg;

  localparam int LINE_W        = 8;
  localparam int DEF_NUM_LINES = 168;

  typedef enum logic [1:0] {
    CMD_NOP        = 2'd0,
    CMD_WRITE_LINE = 2'd1,
    CMD_CLEAR_ALL  = 2'd2
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_INIT_CLR = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_WAIT     = 2'd3
  } seq_state_e;

  // Gate lines are 1-based; an empty or reversed range is rejected.
  function automatic logic range_ok(input logic [LINE_W-1:0] first,
                                    input logic [LINE_W-1:0] last,
                                    input logic [LINE_W-1:0] max_line);
    return (first != '0) && (first <= last) && (last <= max_line);
  endfunction

endpackage

// File: rtl/sharp_vcom_timer.sv
// Free-running VCOM half-period counter: wraps after HALF cycles, toggling
// the vcom level and flagging the wrap cycle.
module sharp_vcom_timer #(
  parameter int HALF = 6_000_000
) (
  input  logic Clk_12MHz,
  input  logic Rst_n,
  output logic vcom,
  output logic wrap
);

  localparam int             CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0]  TC = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  assign wrap = (cnt == TC);

  always_ff @(posedge Clk_12MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt  <= '0;
      vcom <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      vcom <= ~vcom;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sharp_frame_sequencer.sv
// Frame sequencer for a Sharp memory LCD: turns frame/clear requests and the
// VCOM schedule into a stream of one-at-a-time commands for the line engine.
module sharp_frame_sequencer
  import sharp_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int VCOM_HZ   = 1,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int VCOM_SW   = 0
) (
  input  logic              Clk_12MHz,
  input  logic              Rst_n,
  input  logic              frame_start,
  input  logic [LINE_W-1:0] first_line,
  input  logic [LINE_W-1:0] last_line,
  input  logic              clear_req,
  // cmd_valid rises with all cmd_* fields; fields hold and valid stays high
  // until the cycle cmd_valid && cmd_ready, which is the transfer.
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [LINE_W-1:0] cmd_addr,
  output logic              cmd_last,
  output logic              cmd_vcom,
  input  logic              eng_done,
  output logic              EXTCOMIN,
  output logic              DISP,
  output logic              busy,
  output logic              done,
  output logic              err,
  output seq_state_e        dbg_state
);

  localparam int                HALF     = CLK_HZ / (2 * VCOM_HZ);
  localparam logic [LINE_W-1:0] MAX_LINE = LINE_W'(NUM_LINES);

  seq_state_e        state, state_nxt;
  cmd_type_e         cmd_type_q;
  logic              vcom, wrap;
  logic              clear_pend, frame_pend, nop_pend;
  logic [LINE_W-1:0] pend_first, pend_last;
  logic              frame_active;
  logic [LINE_W-1:0] next_line, frame_last;

  logic              accept, frame_in_ok, clear_any, frame_any;
  logic [LINE_W-1:0] sel_first, sel_last;
  logic              load, ld_last, take_clear, take_frame, take_cont;
  cmd_type_e         ld_type;
  logic [LINE_W-1:0] ld_addr;

  sharp_vcom_timer #(.HALF(HALF)) u_vcom_timer (
    .Clk_12MHz (Clk_12MHz),
    .Rst_n     (Rst_n),
    .vcom      (vcom),
    .wrap      (wrap)
  );

  assign accept      = cmd_valid && cmd_ready;
  assign frame_in_ok = frame_start && range_ok(first_line, last_line, MAX_LINE);
  assign clear_any   = clear_pend || clear_req;
  assign frame_any   = frame_pend || frame_in_ok;
  // A request in the decision cycle itself is newer than any pending range.
  assign sel_first   = frame_in_ok ? first_line : pend_first;
  assign sel_last    = frame_in_ok ? last_line  : pend_last;

  assign cmd_type  = cmd_type_q;
  assign EXTCOMIN  = (VCOM_SW == 0) ? vcom : 1'b0;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge Clk_12MHz or negedge Rst_n) begin
    if (!Rst_n) state <= ST_INIT_CLR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    ld_type    = CMD_NOP;
    ld_addr    = '0;
    ld_last    = 1'b0;
    take_clear = 1'b0;
    take_frame = 1'b0;
    take_cont  = 1'b0;
    case (state)
      ST_INIT_CLR: begin
        load      = 1'b1;
        ld_type   = CMD_CLEAR_ALL;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (accept) state_nxt = ST_WAIT;
      end
      ST_IDLE, ST_WAIT: begin
        if (state == ST_IDLE || eng_done) begin
          // An in-progress frame outranks a queued frame; a clear abandons it.
          if (clear_any) begin
            load       = 1'b1;
            ld_type    = CMD_CLEAR_ALL;
            take_clear = 1'b1;
          end else if (frame_active) begin
            load      = 1'b1;
            ld_type   = CMD_WRITE_LINE;
            ld_addr   = next_line;
            ld_last   = (next_line == frame_last);
            take_cont = 1'b1;
          end else if (frame_any) begin
            load       = 1'b1;
            ld_type    = CMD_WRITE_LINE;
            ld_addr    = sel_first;
            ld_last    = (sel_first == sel_last);
            take_frame = 1'b1;
          end else if (nop_pend) begin
            load    = 1'b1;
            ld_type = CMD_NOP;
          end
          state_nxt = load ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_nxt = ST_INIT_CLR;
    endcase
  end

  always_ff @(posedge Clk_12MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      cmd_valid    <= 1'b0;
      cmd_type_q   <= CMD_NOP;
      cmd_addr     <= '0;
      cmd_last     <= 1'b0;
      cmd_vcom     <= 1'b0;
      clear_pend   <= 1'b0;
      frame_pend   <= 1'b0;
      nop_pend     <= 1'b0;
      pend_first   <= '0;
      pend_last    <= '0;
      frame_active <= 1'b0;
      next_line    <= '0;
      frame_last   <= '0;
      DISP         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (load) begin
        cmd_valid  <= 1'b1;
        cmd_type_q <= ld_type;
        cmd_addr   <= ld_addr;
        cmd_last   <= ld_last;
        cmd_vcom   <= (VCOM_SW != 0) ? vcom : 1'b0;
      end else if (accept) begin
        cmd_valid  <= 1'b0;
      end

      clear_pend <= clear_any && !take_clear;

      if (frame_in_ok && !take_frame) begin
        frame_pend <= 1'b1;
        pend_first <= first_line;
        pend_last  <= last_line;
      end else if (take_frame) begin
        frame_pend <= 1'b0;
      end

      if (take_clear) begin
        frame_active <= 1'b0;
      end else if (take_cont) begin
        frame_active <= !ld_last;
        next_line    <= next_line + 1'b1;
      end else if (take_frame) begin
        frame_active <= !ld_last;
        next_line    <= sel_first + 1'b1;
        frame_last   <= sel_last;
      end

      // A wrap means M1 changed, so some command must carry the new level.
      if ((VCOM_SW != 0) && wrap) nop_pend <= 1'b1;
      else if (accept)            nop_pend <= 1'b0;

      // The first completion after reset is always the power-up clear.
      if (state == ST_WAIT && eng_done) DISP <= 1'b1;

      done <= (state == ST_WAIT) && eng_done && (cmd_type_q == CMD_WRITE_LINE) && cmd_last;
      err  <= frame_start && !frame_in_ok;
    end
  end

endmodule

// File: tb/tb_sharp_frame_sequencer.sv
// Directed scoreboard bench for sharp_frame_sequencer: a default-parameter
// instance for frame/clear/error traffic and a fast-VCOM instance for NOPs.
module tb_sharp_frame_sequencer;
  import sharp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- DUT A (defaults, VCOM on EXTCOMIN) ----------------
  logic       a_rst_n, a_frame_start, a_clear_req, a_cmd_ready, a_eng_done;
  logic [7:0] a_first_line, a_last_line;
  logic       a_cmd_valid, a_cmd_last, a_cmd_vcom;
  logic [1:0] a_cmd_type;
  logic [7:0] a_cmd_addr;
  logic       a_extcomin, a_disp, a_busy, a_done, a_err;
  seq_state_e a_dbg;

  sharp_frame_sequencer u_dut_a (
    .Clk_12MHz   (clk),
    .Rst_n       (a_rst_n),
    .frame_start (a_frame_start),
    .first_line  (a_first_line),
    .last_line   (a_last_line),
    .clear_req   (a_clear_req),
    .cmd_valid   (a_cmd_valid),
    .cmd_ready   (a_cmd_ready),
    .cmd_type    (a_cmd_type),
    .cmd_addr    (a_cmd_addr),
    .cmd_last    (a_cmd_last),
    .cmd_vcom    (a_cmd_vcom),
    .eng_done    (a_eng_done),
    .EXTCOMIN    (a_extcomin),
    .DISP        (a_disp),
    .busy        (a_busy),
    .done        (a_done),
    .err         (a_err),
    .dbg_state   (a_dbg)
  );

  // ---------------- DUT B (HALF = 10, VCOM in M1) ----------------
  logic       b_rst_n, b_eng_done;
  logic       b_cmd_valid, b_cmd_last, b_cmd_vcom;
  logic [1:0] b_cmd_type;
  logic [7:0] b_cmd_addr;
  logic       b_extcomin, b_disp, b_busy, b_done, b_err;
  seq_state_e b_dbg;

  sharp_frame_sequencer #(
    .CLK_HZ  (1000),
    .VCOM_HZ (50),
    .VCOM_SW (1)
  ) u_dut_b (
    .Clk_12MHz   (clk),
    .Rst_n       (b_rst_n),
    .frame_start (1'b0),
    .first_line  (8'd0),
    .last_line   (8'd0),
    .clear_req   (1'b0),
    .cmd_valid   (b_cmd_valid),
    .cmd_ready   (1'b1),
    .cmd_type    (b_cmd_type),
    .cmd_addr    (b_cmd_addr),
    .cmd_last    (b_cmd_last),
    .cmd_vcom    (b_cmd_vcom),
    .eng_done    (b_eng_done),
    .EXTCOMIN    (b_extcomin),
    .DISP        (b_disp),
    .busy        (b_busy),
    .done        (b_done),
    .err         (b_err),
    .dbg_state   (b_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [11:0] a_exp_q[$];
  logic [11:0] b_exp_q[$];
  int a_done_cnt = 0, a_err_cnt = 0, a_acc_cnt = 0, b_acc_cnt = 0;
  int b_prev_nop_cyc = -1;

  function automatic logic [11:0] pk(input logic [1:0] t, input logic [7:0] a,
                                     input logic l, input logic v);
    return {t, a, l, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
    if (a_err)  a_err_cnt++;
    if (a_cmd_valid && a_cmd_ready) begin
      a_acc_cnt++;
      if (a_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_cmd actual=0x%0h expected=none",
                 pk(a_cmd_type, a_cmd_addr, a_cmd_last, a_cmd_vcom));
      end else begin
        chk("a_cmd", pk(a_cmd_type, a_cmd_addr, a_cmd_last, a_cmd_vcom), a_exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (b_cmd_valid) begin
      b_acc_cnt++;
      if (b_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_cmd actual=0x%0h expected=none",
                 pk(b_cmd_type, b_cmd_addr, b_cmd_last, b_cmd_vcom));
      end else begin
        chk("b_cmd", pk(b_cmd_type, b_cmd_addr, b_cmd_last, b_cmd_vcom), b_exp_q.pop_front());
      end
      if (b_cmd_type == CMD_NOP) begin
        if (b_prev_nop_cyc >= 0) chk("b_nop_period", cyc - b_prev_nop_cyc, 10);
        b_prev_nop_cyc = cyc;
      end
    end
  end

  // ---------------- engine models ----------------
  initial begin
    a_eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (a_cmd_valid && a_cmd_ready) begin
        repeat (4) @(posedge clk);
        #1 a_eng_done = 1'b1;
        @(posedge clk);
        #1 a_eng_done = 1'b0;
      end
    end
  end

  initial begin
    b_eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (b_cmd_valid) begin
        @(posedge clk);
        #1 b_eng_done = 1'b1;
        @(posedge clk);
        #1 b_eng_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic fs, input logic clr, input logic [7:0] f, input logic [7:0] l);
    @(posedge clk); #1;
    a_frame_start = fs;
    a_clear_req   = clr;
    a_first_line  = f;
    a_last_line   = l;
    @(posedge clk); #1;
    a_frame_start = 1'b0;
    a_clear_req   = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    a_cmd_ready = r;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!a_busy && !a_cmd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s_timeout actual=busy expected=idle", name);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  int d0, e0, c0;

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_frame_start = 1'b0; a_clear_req = 1'b0;
    a_first_line = 8'd0; a_last_line = 8'd0;
    a_cmd_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", a_cmd_valid, 0);
    chk("rst_cmd_type",  a_cmd_type, 0);
    chk("rst_cmd_addr",  a_cmd_addr, 0);
    chk("rst_busy",      a_busy, 1);
    chk("rst_disp",      a_disp, 0);
    chk("rst_done_err",  {a_done, a_err}, 0);
    chk("rst_extcomin",  a_extcomin, 0);
    chk("rst_state",     a_dbg, ST_INIT_CLR);

    // Power-up clear, then display enabled and idle
    a_exp_q.push_back(pk(CMD_CLEAR_ALL, 8'd0, 1'b0, 1'b0));
    a_rst_n = 1'b1;
    wait_idle("init");
    chk("init_disp", a_disp, 1);
    chk("init_busy", a_busy, 0);
    chk("init_state", a_dbg, ST_IDLE);
    chk("init_no_done", a_done_cnt, 0);

    // Frame 10..12
    d0 = a_done_cnt;
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd10, 1'b0, 1'b0));
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd11, 1'b0, 1'b0));
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd12, 1'b1, 1'b0));
    pulse(1'b1, 1'b0, 8'd10, 8'd12);
    @(negedge clk);
    chk("frame_valid_next", a_cmd_valid, 1);
    chk("frame_first_addr", a_cmd_addr, 10);
    wait_idle("frame_10_12");
    chk("frame_done_once", a_done_cnt - d0, 1);

    // Illegal ranges
    e0 = a_err_cnt; c0 = a_acc_cnt;
    pulse(1'b1, 1'b0, 8'd20, 8'd5);
    pulse(1'b1, 1'b0, 8'd0, 8'd3);
    pulse(1'b1, 1'b0, 8'd1, 8'd169);
    repeat (3) @(negedge clk);
    chk("err_pulses", a_err_cnt - e0, 3);
    chk("err_no_cmd", a_acc_cnt - c0, 0);
    chk("err_valid_low", a_cmd_valid, 0);

    // Clear during line 51 of 50..60
    d0 = a_done_cnt;
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd50, 1'b0, 1'b0));
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd51, 1'b0, 1'b0));
    a_exp_q.push_back(pk(CMD_CLEAR_ALL, 8'd0, 1'b0, 1'b0));
    pulse(1'b1, 1'b0, 8'd50, 8'd60);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (a_cmd_valid && a_cmd_addr == 8'd51) begin
          seen = 1'b1;
          break;
        end
      end
      chk("line51_seen", seen, 1);
    end
    pulse(1'b0, 1'b1, 8'd0, 8'd0);
    wait_idle("clear_mid_frame");
    chk("clear_mid_no_done", a_done_cnt - d0, 0);

    // Backpressure: fields stable for 20 cycles
    d0 = a_done_cnt;
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd100, 1'b1, 1'b0));
    set_ready(1'b0);
    pulse(1'b1, 1'b0, 8'd100, 8'd100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", a_cmd_valid, 1);
      chk("hold_fields", {a_cmd_type, a_cmd_addr, a_cmd_last}, {CMD_WRITE_LINE, 8'd100, 1'b1});
    end
    set_ready(1'b1);
    wait_idle("backpressure");
    chk("hold_done", a_done_cnt - d0, 1);

    // Simultaneous clear + frame in IDLE: clear first
    d0 = a_done_cnt;
    a_exp_q.push_back(pk(CMD_CLEAR_ALL, 8'd0, 1'b0, 1'b0));
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd5, 1'b0, 1'b0));
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd6, 1'b1, 1'b0));
    pulse(1'b1, 1'b1, 8'd5, 8'd6);
    wait_idle("clear_and_frame");
    chk("clear_frame_done", a_done_cnt - d0, 1);

    // Pending frame range overwritten by a later request
    d0 = a_done_cnt;
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd30, 1'b1, 1'b0));
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd70, 1'b1, 1'b0));
    set_ready(1'b0);
    pulse(1'b1, 1'b0, 8'd30, 8'd30);
    pulse(1'b1, 1'b0, 8'd40, 8'd41);
    pulse(1'b1, 1'b0, 8'd70, 8'd70);
    set_ready(1'b1);
    wait_idle("pend_overwrite");
    chk("pend_overwrite_done", a_done_cnt - d0, 2);
    chk("a_extcomin_static", a_extcomin, 0);

    // Reset in the middle of a command
    d0 = a_done_cnt; c0 = a_acc_cnt;
    a_exp_q.push_back(pk(CMD_WRITE_LINE, 8'd80, 1'b0, 1'b0));
    pulse(1'b1, 1'b0, 8'd80, 8'd81);
    begin
      bit acc = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (a_acc_cnt != c0) begin
          acc = 1'b1;
          break;
        end
      end
      chk("mid_reset_accept", acc, 1);
    end
    @(posedge clk); #1 a_rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_reset_valid", a_cmd_valid, 0);
    chk("mid_reset_disp", a_disp, 0);
    chk("mid_reset_busy", a_busy, 1);
    a_exp_q.push_back(pk(CMD_CLEAR_ALL, 8'd0, 1'b0, 1'b0));
    a_rst_n = 1'b1;
    wait_idle("after_reset");
    chk("mid_reset_no_done", a_done_cnt - d0, 0);
    chk("after_reset_disp", a_disp, 1);

    // DUT B: VCOM carried as NOP commands every HALF = 10 cycles
    b_exp_q.push_back(pk(CMD_CLEAR_ALL, 8'd0, 1'b0, 1'b0));
    b_exp_q.push_back(pk(CMD_NOP, 8'd0, 1'b0, 1'b1));
    b_exp_q.push_back(pk(CMD_NOP, 8'd0, 1'b0, 1'b0));
    b_exp_q.push_back(pk(CMD_NOP, 8'd0, 1'b0, 1'b1));
    @(negedge clk);
    b_rst_n = 1'b1;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (b_acc_cnt == 4) begin
          got = 1'b1;
          break;
        end
      end
      chk("b_four_cmds", got, 1);
    end
    chk("b_extcomin_low", b_extcomin, 0);
    chk("b_disp", b_disp, 1);
    @(posedge clk); #1 b_rst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("a_queue_empty", a_exp_q.size(), 0);
    chk("b_queue_empty", b_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sharp_frame_sequencer.md
SHARP_FRAME_SEQUENCER -- requirements
Module: sharp_frame_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 12_000_000, input clock frequency in Hz.
REQ-002 Parameter VCOM_HZ, default 1, VCOM inversion frequency in Hz; half-period HALF = CLK_HZ/(2*VCOM_HZ) cycles.
REQ-003 Parameter NUM_LINES, default 168, panel gate lines, 1-based addresses 1..NUM_LINES.
REQ-004 Parameter VCOM_SW, default 0: 0 = VCOM driven on EXTCOMIN pin; 1 = VCOM carried in the command M1 bit.
REQ-005 Clk_12MHz  in  1  system clock; all logic on the rising edge.
REQ-006 Rst_n  in  1  asynchronous, active-low reset.
REQ-007 frame_start  in  1  single-cycle pulse requesting a refresh of lines first_line..last_line.
REQ-008 first_line, last_line  in  8 each  inclusive line range, sampled in the frame_start cycle.
REQ-009 clear_req  in  1  single-cycle pulse requesting an all-clear.
REQ-010 cmd_valid / cmd_ready  out / in  1 each  command handshake to the serial line engine.
REQ-011 cmd_type  out  2  0=NOP, 1=WRITE_LINE, 2=CLEAR_ALL.
REQ-012 cmd_addr  out  8  gate line for WRITE_LINE, else 0.
REQ-013 cmd_last  out  1  last WRITE_LINE of a frame (engine appends trailer).
REQ-014 cmd_vcom  out  1  M1 bit; equals vcom state when VCOM_SW=1, else 0.
REQ-015 eng_done  in  1  pulse: engine finished the accepted command.
REQ-016 EXTCOMIN  out  1  VCOM square wave when VCOM_SW=0, else 0.
REQ-017 DISP  out  1  display enable.
REQ-018 busy, done, err  out  1 each  command in flight; frame-complete pulse; rejected-request pulse.

Function
REQ-019 States: INIT_CLR, IDLE, ISSUE, WAIT; ISSUE holds cmd_valid, WAIT awaits eng_done.
REQ-020 One command outstanding at most; ISSUE->WAIT on cmd_valid&&cmd_ready; WAIT->IDLE or ISSUE on eng_done.
REQ-021 cmd_type/addr/last/vcom stable while cmd_valid && !cmd_ready; cmd_valid never drops before acceptance.
REQ-022 frame_start in IDLE with legal range -> cmd_valid high the next cycle, cmd_addr=first_line.
REQ-023 Legal range: 1 <= first_line <= last_line <= NUM_LINES; otherwise err pulses 1 cycle and the request is discarded.
REQ-024 Lines issued in ascending order, one WRITE_LINE per line; cmd_last=1 only on last_line.
REQ-025 done pulses 1 cycle on eng_done of the cmd_last command.
REQ-026 Requests arriving while busy latch into one-deep pending flags (clear_pend, frame_pend + range); a second frame_start while frame_pend is set overwrites the range.
REQ-027 Arbitration on each decision point, priority clear_pend > frame_pend > nop_pend.
REQ-028 clear_req during a frame: the in-flight line completes, remaining lines are abandoned, CLEAR_ALL issues next, done is not pulsed; frame_pend survives.
REQ-029 Simultaneous clear_req and frame_start in IDLE: CLEAR_ALL first, then the frame.
REQ-030 VCOM timer free-runs with terminal count HALF-1, toggling vcom state on wrap, in every state.
REQ-031 VCOM_SW=1: timer wrap sets nop_pend; nop_pend clears on acceptance of any command, because each command carries current M1.
REQ-032 DISP rises on eng_done of the INIT_CLR CLEAR_ALL and stays high until reset.
REQ-033 busy = state != IDLE.

Reset
REQ-034 Rst_n low: state=INIT_CLR, cmd_valid=0, cmd_type=0, cmd_addr=0, cmd_last=0, cmd_vcom=0, EXTCOMIN=0, DISP=0, busy=1, done=0, err=0, pending flags=0, timer=0.
REQ-035 After Rst_n release, INIT_CLR issues CLEAR_ALL on the first clock; frame_start/clear_req received before its eng_done latch as pending.
REQ-036 Reset mid-command abandons the command with no completion pulse.

Structure
REQ-037 Shared package sharp_pkg holds cmd_type encodings, NUM_LINES, and the line-address width.
REQ-038 Sub-module sharp_vcom_timer (counter plus toggle, wrap pulse) instantiated once.

Verification
REQ-039 Reset release, engine ready, eng_done 4 cycles after accept -> CLEAR_ALL, then DISP=1, busy=0.
REQ-040 frame_start 10..12 -> WRITE_LINE 10, 11, 12; cmd_last only on 12; one done pulse.
REQ-041 frame_start 20..5, then 0..3, then 1..169 -> three err pulses, no cmd_valid.
REQ-042 clear_req during line 51 of 50..60 -> line 51 completes, CLEAR_ALL next, no done.
REQ-043 cmd_ready held low 20 cycles -> cmd fields constant, cmd_valid held.
REQ-044 CLK_HZ=1000, VCOM_HZ=50, VCOM_SW=1, idle -> NOP every 10 cycles, cmd_vcom alternating 1,0,1.
